// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back front end.
package regfile_pkg;

  localparam int NUM_REG   = 16;
  localparam int SEL_WIDTH = 4;
  localparam int D_WIDTH   = 34;

  // One pending register write: destination select plus data.
  typedef struct packed {
    logic [SEL_WIDTH-1:0] wa;
    logic [D_WIDTH-1:0]   wd;
  } wb_req_t;

  // Producer identity; also used as the round-robin pointer value.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small per-source write-back FIFO. No fall-through: a push into an empty
// FIFO becomes visible at the head on the following cycle. Every entry is
// exposed alongside a valid vector so the top can build the pending mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_req_t               head,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   entry_vld
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   cnt;
  wb_req_t       mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // A slot holds live data when its distance from the read pointer
  // (modulo DEPTH, via natural pointer wrap) is below the occupancy.
  function automatic logic slot_valid(input logic [PW-1:0] slot,
                                      input logic [PW-1:0] rd,
                                      input logic [PW:0]   n);
    logic [PW-1:0] off;
    off = slot - rd;
    return ({1'b0, off} < n);
  endfunction

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves cnt unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage; only control state needs reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Expose every slot and whether it currently holds a queued write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]   = mem[i];
      entry_vld[i] = slot_valid(PW'(i), rd_ptr, cnt);
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Write-back front end for the register file: buffers ALU and MEM results,
// arbitrates round-robin, issues at most one write per cycle and publishes
// a per-register pending mask for hazard stalls.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int NUM_REG   = 16,
  parameter int SEL_WIDTH = 4,
  parameter int D_WIDTH   = 34,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [SEL_WIDTH-1:0] alu_wa_i,
  input  logic [D_WIDTH-1:0]   alu_wd_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [SEL_WIDTH-1:0] mem_wa_i,
  input  logic [D_WIDTH-1:0]   mem_wd_i,
  output logic                 wen_o,
  output logic [SEL_WIDTH-1:0] wa_o,
  output logic [D_WIDTH-1:0]   wd_o,
  output logic [NUM_REG-1:0]   pend_o,
  output logic                 busy_o
);

  wb_req_t               alu_req_p0;
  wb_req_t               mem_req_p0;
  wb_req_t               alu_head_p0;
  wb_req_t               mem_head_p0;
  wb_req_t               head_sel_p0;
  wb_req_t [DEPTH-1:0]   alu_entries;
  wb_req_t [DEPTH-1:0]   mem_entries;
  logic    [DEPTH-1:0]   alu_entry_vld;
  logic    [DEPTH-1:0]   mem_entry_vld;
  logic                  alu_full;
  logic                  alu_empty;
  logic                  mem_full;
  logic                  mem_empty;
  logic                  alu_push;
  logic                  mem_push;
  logic                  gnt_alu;
  logic                  gnt_mem;
  src_e                  rr_ptr;
  logic                  vld_p1;
  logic [SEL_WIDTH-1:0]  wa_p1;
  logic [D_WIDTH-1:0]    wd_p1;
  logic [NUM_REG-1:0]    pend;

  function automatic logic [NUM_REG-1:0] reg_onehot(input logic [SEL_WIDTH-1:0] sel);
    logic [NUM_REG-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

  // Ready depends only on registered FIFO occupancy.
  assign alu_ready_o = ~alu_full;
  assign mem_ready_o = ~mem_full;
  assign alu_push    = alu_valid_i & alu_ready_o;
  assign mem_push    = mem_valid_i & mem_ready_o;

  assign alu_req_p0  = '{wa: alu_wa_i, wd: alu_wd_i};
  assign mem_req_p0  = '{wa: mem_wa_i, wd: mem_wd_i};

  // ---- stage p0: per-source FIFOs ----
  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .push_data (alu_req_p0),
    .pop       (gnt_alu),
    .full      (alu_full),
    .empty     (alu_empty),
    .head      (alu_head_p0),
    .entries   (alu_entries),
    .entry_vld (alu_entry_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_push),
    .push_data (mem_req_p0),
    .pop       (gnt_mem),
    .full      (mem_full),
    .empty     (mem_empty),
    .head      (mem_head_p0),
    .entries   (mem_entries),
    .entry_vld (mem_entry_vld)
  );

  // Round-robin grant: a lone non-empty source wins, contention follows rr_ptr.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!alu_empty && !mem_empty) begin
      if (rr_ptr == SRC_ALU) gnt_alu = 1'b1;
      else                   gnt_mem = 1'b1;
    end else if (!alu_empty) begin
      gnt_alu = 1'b1;
    end else if (!mem_empty) begin
      gnt_mem = 1'b1;
    end
  end

  assign head_sel_p0 = gnt_mem ? mem_head_p0 : alu_head_p0;

  // Pointer always moves to the source that lost (or did not request).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= SRC_ALU;
    else if (gnt_alu) rr_ptr <= SRC_MEM;
    else if (gnt_mem) rr_ptr <= SRC_ALU;
  end

  // ---- stage p1: output register driving the regfile write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      wa_p1  <= '0;
      wd_p1  <= '0;
    end else begin
      vld_p1 <= gnt_alu | gnt_mem;
      if (gnt_alu | gnt_mem) begin
        wa_p1 <= head_sel_p0.wa;
        wd_p1 <= head_sel_p0.wd;
      end
    end
  end

  // Pending mask: every queued destination plus the one being presented.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_entry_vld[i]) pend = pend | reg_onehot(alu_entries[i].wa);
      if (mem_entry_vld[i]) pend = pend | reg_onehot(mem_entries[i].wa);
    end
    if (vld_p1) pend = pend | reg_onehot(wa_p1);
  end

  assign wen_o  = vld_p1;
  assign wa_o   = wa_p1;
  assign wd_o   = wd_p1;
  assign pend_o = pend;
  assign busy_o = ~alu_empty | ~mem_empty | vld_p1;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: queue-based reference model feeding a per-cycle
// expectation queue, with an independent monitor popping and comparing.
module tb_regfile_wb;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_valid_i, mem_valid_i;
  logic        alu_ready_o, mem_ready_o;
  logic [3:0]  alu_wa_i, mem_wa_i;
  logic [33:0] alu_wd_i, mem_wd_i;
  logic        wen_o;
  logic [3:0]  wa_o;
  logic [33:0] wd_o;
  logic [15:0] pend_o;
  logic        busy_o;

  regfile_wb #(.NUM_REG(16), .SEL_WIDTH(4), .D_WIDTH(34), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_wa_i(alu_wa_i), .alu_wd_i(alu_wd_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_wa_i(mem_wa_i), .mem_wd_i(mem_wd_i),
    .wen_o(wen_o), .wa_o(wa_o), .wd_o(wd_o),
    .pend_o(pend_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [3:0]  wa;
    logic [33:0] wd;
    logic [15:0] pend;
    logic        busy;
    logic        ra;
    logic        rm;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int dut_writes = 0;
  int acc_total = 0;

  // Reference model: contents of each source queue, who wins next tie,
  // and what the write port shows this cycle.
  wb_req_t aq[$];
  wb_req_t mq[$];
  logic    rr_mem;
  logic        m_wen;
  logic [3:0]  m_wa;
  logic [33:0] m_wd;
  exp_t    exp_q[$];

  // Producer-side pending items.
  wb_req_t a_items[$];
  wb_req_t m_items[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic wb_req_t rand_req();
    wb_req_t r;
    r.wa = 4'($urandom_range(15, 0));
    r.wd = {2'($urandom_range(3, 0)), 32'($urandom())};
    return r;
  endfunction

  function automatic wb_req_t mk(input int wa, input logic [33:0] wd);
    wb_req_t r;
    r.wa = 4'(wa);
    r.wd = wd;
    return r;
  endfunction

  task automatic model_clear();
    aq.delete();
    mq.delete();
    rr_mem = 1'b0;
    m_wen  = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    exp_q.delete();
  endtask

  task automatic push_exp();
    exp_t e;
    logic [15:0] p;
    p = '0;
    foreach (aq[i]) p[aq[i].wa] = 1'b1;
    foreach (mq[i]) p[mq[i].wa] = 1'b1;
    if (m_wen) p[m_wa] = 1'b1;
    e.wen  = m_wen;
    e.wa   = m_wa;
    e.wd   = m_wd;
    e.pend = p;
    e.busy = (aq.size() > 0) || (mq.size() > 0) || m_wen;
    e.ra   = (aq.size() < DEPTH);
    e.rm   = (mq.size() < DEPTH);
    exp_q.push_back(e);
  endtask

  // One clock edge of the reference model.
  task automatic model_step();
    wb_req_t ent;
    logic acc_a, acc_m;
    if (!rst_n) begin
      model_clear();
      push_exp();
      return;
    end
    acc_a = alu_valid_i && (aq.size() < DEPTH);
    acc_m = mem_valid_i && (mq.size() < DEPTH);
    if (aq.size() > 0 && (mq.size() == 0 || !rr_mem)) begin
      ent = aq.pop_front();
      m_wen = 1'b1; m_wa = ent.wa; m_wd = ent.wd;
      rr_mem = 1'b1;
    end else if (mq.size() > 0) begin
      ent = mq.pop_front();
      m_wen = 1'b1; m_wa = ent.wa; m_wd = ent.wd;
      rr_mem = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (acc_a) aq.push_back(mk(int'(alu_wa_i), alu_wd_i));
    if (acc_m) mq.push_back(mk(int'(mem_wa_i), mem_wd_i));
    push_exp();
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare the DUT against the expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wen_o === 1'b1) dut_writes++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wen", 64'(wen_o), 64'(e.wen));
        chk("wa", 64'(wa_o), 64'(e.wa));
        chk("wd", 64'(wd_o), 64'(e.wd));
        chk("pend", 64'(pend_o), 64'(e.pend));
        chk("busy", 64'(busy_o), 64'(e.busy));
        chk("alu_ready", 64'(alu_ready_o), 64'(e.ra));
        chk("mem_ready", 64'(mem_ready_o), 64'(e.rm));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    alu_valid_i = 1'b0;
    mem_valid_i = 1'b0;
    a_items.delete();
    m_items.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_writes = 0;
    acc_total = 0;
  endtask

  // Producers: valid is held until accepted; pa/pm are presentation odds in %.
  logic alu_low_seen;
  task automatic run_cycles(input int n, input int pa, input int pm);
    wb_req_t ent;
    logic a_acc, m_acc;
    for (int c = 0; c < n; c++) begin
      if (!alu_valid_i && a_items.size() > 0 && $urandom_range(99, 0) < pa) begin
        ent = a_items.pop_front();
        alu_valid_i = 1'b1; alu_wa_i = ent.wa; alu_wd_i = ent.wd;
      end
      if (!mem_valid_i && m_items.size() > 0 && $urandom_range(99, 0) < pm) begin
        ent = m_items.pop_front();
        mem_valid_i = 1'b1; mem_wa_i = ent.wa; mem_wd_i = ent.wd;
      end
      if (!alu_ready_o) alu_low_seen = 1'b1;
      a_acc = alu_valid_i && alu_ready_o;
      m_acc = mem_valid_i && mem_ready_o;
      @(posedge clk);
      #1;
      if (a_acc) begin acc_total++; alu_valid_i = 1'b0; end
      if (m_acc) begin acc_total++; mem_valid_i = 1'b0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    alu_wa_i = '0; alu_wd_i = '0; mem_wa_i = '0; mem_wd_i = '0;
    alu_low_seen = 1'b0;
    apply_reset();
    chk("reset_wen", 64'(wen_o), 64'd0);
    chk("reset_pend", 64'(pend_o), 64'd0);
    chk("reset_alu_ready", 64'(alu_ready_o), 64'd1);

    // Single ALU write: latency and pending window.
    alu_valid_i = 1'b1; alu_wa_i = 4'd3; alu_wd_i = 34'h1_2345_6789;
    tick();
    alu_valid_i = 1'b0;
    chk("t1_c2_wen", 64'(wen_o), 64'd0);
    chk("t1_c2_pend", 64'(pend_o), 64'h0008);
    tick();
    chk("t1_c3_wen", 64'(wen_o), 64'd1);
    chk("t1_c3_wa", 64'(wa_o), 64'd3);
    chk("t1_c3_wd", 64'(wd_o), 64'h1_2345_6789);
    chk("t1_c3_pend", 64'(pend_o), 64'h0008);
    tick();
    chk("t1_c4_wen", 64'(wen_o), 64'd0);
    chk("t1_c4_pend", 64'(pend_o), 64'h0000);
    chk("t1_c4_busy", 64'(busy_o), 64'd0);

    // Joint pushes on consecutive edges: contested grants alternate.
    apply_reset();
    alu_valid_i = 1'b1; alu_wa_i = 4'd1; alu_wd_i = 34'd10;
    mem_valid_i = 1'b1; mem_wa_i = 4'd2; mem_wd_i = 34'd20;
    tick();
    alu_wa_i = 4'd4; alu_wd_i = 34'd40;
    mem_wa_i = 4'd5; mem_wd_i = 34'd50;
    tick();
    alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    chk("t2_w1_wa", 64'(wa_o), 64'd1);
    chk("t2_w1_wd", 64'(wd_o), 64'd10);
    tick();
    chk("t2_w2_wa", 64'(wa_o), 64'd2);
    chk("t2_w2_wd", 64'(wd_o), 64'd20);
    tick();
    chk("t2_w3_wa", 64'(wa_o), 64'd4);
    tick();
    chk("t2_w4_wa", 64'(wa_o), 64'd5);
    chk("t2_w4_wen", 64'(wen_o), 64'd1);
    tick();

    // Back-to-back MEM writes to r7 then r9: pending mask sequence.
    mem_valid_i = 1'b1; mem_wa_i = 4'd7; mem_wd_i = 34'h7;
    tick();
    chk("t4_pend_a", 64'(pend_o), 64'h0080);
    mem_wa_i = 4'd9; mem_wd_i = 34'h9;
    tick();
    mem_valid_i = 1'b0;
    chk("t4_pend_b", 64'(pend_o), 64'h0280);
    chk("t4_wa_b", 64'(wa_o), 64'd7);
    tick();
    chk("t4_pend_c", 64'(pend_o), 64'h0200);
    chk("t4_wa_c", 64'(wa_o), 64'd9);
    tick();
    chk("t4_pend_d", 64'(pend_o), 64'h0000);

    // Sustained ALU burst of 5 against 3 MEM entries.
    apply_reset();
    alu_low_seen = 1'b0;
    for (int i = 0; i < 5; i++) a_items.push_back(mk(i + 1, 34'(100 + i)));
    for (int i = 0; i < 3; i++) m_items.push_back(mk(i + 8, 34'(200 + i)));
    run_cycles(20, 100, 100);
    chk("t3_alu_ready_fell", 64'(alu_low_seen), 64'd1);
    chk("t3_writes", 64'(dut_writes), 64'd8);

    // Fill both FIFOs and pulse reset mid-cycle.
    apply_reset();
    for (int i = 0; i < 4; i++) a_items.push_back(mk(i + 1, 34'(300 + i)));
    for (int i = 0; i < 4; i++) m_items.push_back(mk(i + 10, 34'(400 + i)));
    run_cycles(4, 100, 100);
    #1;
    chk("t5_wen_before", 64'(wen_o), 64'd1);
    chk("t5_busy_before", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    a_items.delete(); m_items.delete();
    model_clear();
    #1;
    chk("t5_async_wen", 64'(wen_o), 64'd0);
    chk("t5_async_pend", 64'(pend_o), 64'd0);
    chk("t5_async_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_writes = 0;
    chk("t5_alu_ready", 64'(alu_ready_o), 64'd1);
    chk("t5_mem_ready", 64'(mem_ready_o), 64'd1);
    run_cycles(6, 100, 100);
    chk("t5_no_stale", 64'(dut_writes), 64'd0);

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 6000; i++) a_items.push_back(rand_req());
    for (int i = 0; i < 6000; i++) m_items.push_back(rand_req());
    run_cycles(10000, 60, 50);
    a_items.delete(); m_items.delete();
    guard = 0;
    while ((alu_valid_i || mem_valid_i || busy_o) && guard < 50) begin
      run_cycles(1, 0, 0);
      guard++;
    end
    chk("t6_drained", 64'(guard < 50), 64'd1);
    run_cycles(2, 0, 0);
    chk("t6_write_count", 64'(dut_writes), 64'(acc_total));
    chk("t6_busy_end", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
